// File: rtl/tdpr.sv
// tdpr: true dual-port RAM with post-reset clear sequencer; define TDPR_BYPASS_EN for cross-port write forwarding
module tdpr #(
  parameter int DW = 8,
  parameter int AW = 14,
  parameter int CL = 1,
  parameter logic [DW-1:0] CV = '0,
  parameter string FN = ""
) (
  input  logic          clock,
  input  logic          reset,
  output logic          busy,
  input  logic          we1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d1,
  output logic [DW-1:0] q1,
  input  logic          we2,
  input  logic [AW-1:0] a2,
  input  logic [DW-1:0] d2,
  output logic [DW-1:0] q2
);
`ifdef TDPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] q1_n, q2_n;
  assign busy = (state == CLEAR);
  always_comb begin
    q1_n = we1 ? d1 : (BYP && we2 && a2 == a1) ? d2 : mem[a1];
    q2_n = (we1 && a1 == a2 && (we2 || BYP)) ? d1 : we2 ? d2 : mem[a2];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= (CL != 0) ? CLEAR : RUN;
      cnt <= '0;
      q1 <= '0;
      q2 <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= CV;
      cnt <= cnt + 1'b1;
      state <= (cnt == '1) ? RUN : CLEAR;
      q1 <= '0;
      q2 <= '0;
    end else begin
      if (we2) mem[a2] <= d2;
      if (we1) mem[a1] <= d1;
      q1 <= q1_n;
      q2 <= q2_n;
    end
  end
endmodule
